// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes, master state encoding and default widths.
package axi_lite_pkg;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} mst_state_t;
endpackage

// File: rtl/axi_timeout_cnt.sv
// axi_timeout_cnt: watchdog counter; clk/rst, clr restarts from 0, en counts, expired flags LIMIT-1 reached (LIMIT=0 never expires).
module axi_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = LIMIT < 2 ? 1 : $clog2(LIMIT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) cnt <= (rst || clr) ? '0 : en ? cnt + 1'b1 : cnt;
  // the count includes the accepting edge, so expiry here aborts on the edge where it would reach LIMIT
  assign expired = (LIMIT != 0) && (cnt >= CW'(LIMIT - 1));
endmodule

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator with response watchdog.
//   ACLK/ARESET (sync, active-high); user side cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata/cmd_wstrb,
//   completion done/done_write/rdata/resp/timeout; AXI-Lite AW/W/B and AR/R master channels.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                done,
  output logic                done_write,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          resp,
  output logic                timeout,
  output logic                AWVALID,
  output logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWREADY,
  output logic                WVALID,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  input  logic                WREADY,
  input  logic                BVALID,
  input  logic [1:0]          BRESP,
  output logic                BREADY,
  output logic                ARVALID,
  output logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARREADY,
  input  logic                RVALID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  output logic                RREADY
);
  mst_state_t state, nxt;
  logic aw_done, w_done, aw_done_n, w_done_n;
  logic aw_n, w_n, b_n, ar_n, r_n;
  logic done_n, dw_n, to_n, abort, expired, accept;
  logic [1:0] resp_n;
  logic [DATA_W-1:0] rdata_n;
  assign cmd_ready = (state == IDLE) && !ARESET;
  assign accept = cmd_valid && cmd_ready;
  axi_timeout_cnt #(.LIMIT(TIMEOUT)) u_wdog (
    .clk(ACLK),
    .rst(ARESET),
    .clr(nxt == IDLE),
    .en(TIMEOUT != 0),
    .expired(expired)
  );
  always_comb begin
    nxt = state;
    aw_n = AWVALID;
    w_n = WVALID;
    b_n = BREADY;
    ar_n = ARVALID;
    r_n = RREADY;
    aw_done_n = aw_done;
    w_done_n = w_done;
    done_n = 1'b0;
    dw_n = done_write;
    to_n = timeout;
    resp_n = resp;
    rdata_n = rdata;
    abort = 1'b0;
    case (state)
      IDLE: if (accept) begin
        nxt = cmd_write ? WR : RD_ADDR;
        aw_n = cmd_write;
        w_n = cmd_write;
        ar_n = !cmd_write;
        aw_done_n = 1'b0;
        w_done_n = 1'b0;
      end
      WR: begin
        // AW and W retire independently; each VALID drops after its own handshake
        aw_done_n = aw_done || (AWVALID && AWREADY);
        w_done_n = w_done || (WVALID && WREADY);
        aw_n = AWVALID && !AWREADY;
        w_n = WVALID && !WREADY;
        if (aw_done_n && w_done_n) begin
          nxt = WR_RESP;
          b_n = 1'b1;
        end else abort = expired;
      end
      WR_RESP: if (BVALID) begin
        nxt = IDLE;
        b_n = 1'b0;
        resp_n = BRESP;
        dw_n = 1'b1;
        to_n = 1'b0;
        done_n = 1'b1;
      end else abort = expired;
      RD_ADDR: if (ARREADY) begin
        nxt = RD_DATA;
        ar_n = 1'b0;
        r_n = 1'b1;
      end else abort = expired;
      RD_DATA: if (RVALID) begin
        nxt = IDLE;
        r_n = 1'b0;
        rdata_n = RDATA;
        resp_n = RRESP;
        dw_n = 1'b0;
        to_n = 1'b0;
        done_n = 1'b1;
      end else abort = expired;
      default: nxt = IDLE;
    endcase
    // watchdog abort withdraws VALID/READY mid-handshake; the slave must be reset afterwards
    if (abort) begin
      nxt = IDLE;
      {aw_n, w_n, b_n, ar_n, r_n} = '0;
      resp_n = SLVERR;
      to_n = 1'b1;
      dw_n = (state == WR) || (state == WR_RESP);
      done_n = 1'b1;
    end
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
      {AWVALID, WVALID, BREADY, ARVALID, RREADY} <= '0;
      {aw_done, w_done} <= '0;
      AWADDR <= '0;
      ARADDR <= '0;
      WDATA <= '0;
      WSTRB <= '0;
      {done, done_write, timeout} <= '0;
      rdata <= '0;
      resp <= '0;
    end else begin
      state <= nxt;
      {AWVALID, WVALID, BREADY, ARVALID, RREADY} <= {aw_n, w_n, b_n, ar_n, r_n};
      {aw_done, w_done} <= {aw_done_n, w_done_n};
      {done, done_write, timeout} <= {done_n, dw_n, to_n};
      rdata <= rdata_n;
      resp <= resp_n;
      if (accept && cmd_write) begin
        AWADDR <= cmd_addr;
        WDATA <= cmd_wdata;
        WSTRB <= cmd_wstrb;
      end
      if (accept && !cmd_write) ARADDR <= cmd_addr;
    end
  end
endmodule
